// File: rtl/i2c_regbank_pkg.sv
// Shared constants and select-decode helpers for the I2C register bank.
package i2c_regbank_pkg;

    localparam int unsigned NUM_REGS   = 11;
    localparam int unsigned REG_W      = 8;
    localparam int unsigned COMMIT_IDX = NUM_REGS - 1;
    localparam int unsigned ADDR_W     = 4;

    function automatic logic [ADDR_W-1:0] onehot_to_idx(input logic [NUM_REGS-1:0] oh);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (oh[i]) idx = idx | ADDR_W'(i);
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [NUM_REGS-1:0] v);
        return (v & (v - NUM_REGS'(1))) != '0;
    endfunction

endpackage

// File: rtl/i2c_reg_bank_sync_2ff.sv
// Two-flop synchroniser, parameterised width, asynchronous active-high reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank written by resynchronised one-hot select pulses from the I2C slave.
// Optional shadow/commit publication under macro I2C_REGBANK_COMMIT_EN.
module i2c_reg_bank
    import i2c_regbank_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_W-1:0]          data_in,
    input  logic [NUM_REGS-1:0]       reg_sel,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic                      wr_strobe,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      commit_pulse,
    output logic                      err_multi
);

    logic [NUM_REGS-1:0] w_sel_s;
    logic [REG_W-1:0]    w_dat_s;
    logic [NUM_REGS-1:0] r_sel_d;
    logic [1:0]          r_prime;
    logic [NUM_REGS-1:0] w_rise;
    logic                w_multi;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_idx;

    logic [REG_W-1:0]    r_regs [NUM_REGS];
    logic                r_wr_strobe;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_err_multi;

    sync_2ff #(.WIDTH(NUM_REGS)) u_sync_sel (
        .clk (clk),
        .rst (rst),
        .d   (reg_sel),
        .q   (w_sel_s)
    );

    sync_2ff #(.WIDTH(REG_W)) u_sync_dat (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (w_dat_s)
    );

    assign w_rise  = w_sel_s & ~r_sel_d;
    assign w_multi = more_than_one(w_rise);
    assign w_wr    = (|w_rise) && !w_multi;
    assign w_idx   = onehot_to_idx(w_rise);

    // Until the synchroniser has refilled after reset, sel_d is forced high so a
    // select already held across reset must first be seen low before it can write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prime <= '0;
            r_sel_d <= '0;
        end else begin
            r_prime <= {r_prime[0], 1'b1};
            r_sel_d <= r_prime[1] ? w_sel_s : '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_err_multi <= 1'b0;
        end else begin
            r_wr_strobe <= w_wr;
            if (w_wr) r_wr_addr <= w_idx;
            if ((|w_rise) && w_multi) r_err_multi <= 1'b1;
        end
    end

`ifdef I2C_REGBANK_COMMIT_EN
    logic [REG_W-1:0] r_shadow [COMMIT_IDX];
    logic             r_commit_pend;
    logic             r_commit_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            for (int unsigned i = 0; i < COMMIT_IDX; i++) r_shadow[i] <= '0;
            r_commit_pend  <= 1'b0;
            r_commit_pulse <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < COMMIT_IDX; i++) begin
                if (w_wr && w_rise[i]) r_shadow[i] <= w_dat_s;
                if (r_commit_pend)     r_regs[i]   <= r_shadow[i];
            end
            if (w_wr && w_rise[COMMIT_IDX]) r_regs[COMMIT_IDX] <= w_dat_s;
            r_commit_pend  <= w_wr && w_rise[COMMIT_IDX] && w_dat_s[0];
            r_commit_pulse <= r_commit_pend;
        end
    end

    assign commit_pulse = r_commit_pulse;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_wr && w_rise[i]) r_regs[i] <= w_dat_s;
            end
        end
    end

    assign commit_pulse = 1'b0;
`endif

    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i*REG_W +: REG_W] = r_regs[i];
        end
    end

    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign err_multi = r_err_multi;

endmodule
